// File: rtl/serial_add_ctrl_pkg.sv
// Shared FSM state encoding and default operand width for the serial adder.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the serial adder's bit cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshake: one operand bit per RUN cycle.
// SERIAL_ADD_OVF_EN enables the registered signed-overflow flag; otherwise ovf is tied to 0.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Current operand bits selected by shifting rather than a variable-width index.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             bit_a, bit_b, bit_p, bit_g0, bit_g1, bit_s, bit_c;

  assign a_sh  = a_q >> cnt_q;
  assign b_sh  = b_q >> cnt_q;
  assign bit_a = a_sh[0];
  assign bit_b = b_sh[0];

  half_adder u_ha0 (.a_i(bit_a), .b_i(bit_b),   .sum_o(bit_p), .carry_o(bit_g0));
  half_adder u_ha1 (.a_i(bit_p), .b_i(carry_q), .sum_o(bit_s), .carry_o(bit_g1));
  assign bit_c = bit_g0 | bit_g1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = 1'b0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_q | (WIDTH'(bit_s) << cnt_q);
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        // Publish to the visible outputs only once all bits are in.
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // Same-sign operands producing an opposite-sign result.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && cnt_q == LAST)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bit_s != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed literal cases.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn, in_valid, out_ready;
  logic [W-1:0] a_in, b_in;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_in), .b(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: remaining RUN cycles, a pending result, and a done flag.
  int           m_rem = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum = '0, m_psum = '0;
  bit           m_cout = 1'b0, m_pcout = 1'b0, m_ovf = 1'b0, m_povf = 1'b0;
  int           cyc = 0;
  int           last_acc = -1;
  int           n_acc = 0;
  bit           b2b = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    logic [W:0] full;
    cyc++;
    if (!resetn) begin
      m_rem = 0; m_done = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_sum = m_psum; m_cout = m_pcout; m_ovf = m_povf;
      end
    end else if (in_valid) begin
      full    = {1'b0, a_in} + {1'b0, b_in};
      m_psum  = full[W-1:0];
      m_pcout = full[W];
      m_povf  = OVF_ON && (((a_in ^ full[W-1:0]) & (b_in ^ full[W-1:0])) >> (W-1)) != 0;
      m_rem   = W;
      n_acc++;
      if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, W + 2);
      last_acc = cyc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  (m_rem == 0 && !m_done));
      chk("busy",      busy,      (m_rem != 0 || m_done));
      chk("out_valid", out_valid, m_done);
      chk("sum",       sum,       m_sum);
      chk("cout",      cout,      m_cout);
      chk("ovf",       ovf,       m_ovf);
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input logic [W-1:0] es, input bit ec, input bit eo);
    int n;
    logic [W-1:0] s0;
    n = 0;
    while (!in_ready && n < 40) begin tick; n++; end
    chk({name, "_idle_timeout"}, in_ready, 1'b1);
    in_valid = 1'b1; a_in = av; b_in = bv; out_ready = 1'b0;
    tick;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    chk({name, "_latency"}, n, W);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, ovf, eo);
    s0 = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick;
      chk({name, "_hold_valid"}, out_valid, 1'b1);
      chk({name, "_hold_ready"}, in_ready, 1'b0);
      chk({name, "_hold_sum"}, sum, s0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk({name, "_release_idle"}, in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n, target;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    tick;
    chk_en = 1'b1;
    tick;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_sum", sum, 0);
    resetn = 1'b1;
    tick;

    run_op("zero",  8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    run_op("carry", 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b0);
    run_op("sovf",  8'h7F, 8'h01, 0, 8'h80, 1'b0, OVF_ON);
    run_op("bp",    8'hC3, 8'h5A, 5, 8'h1D, 1'b1, 1'b0);

    // Abort mid-RUN: no result may appear afterwards.
    in_valid = 1'b1; a_in = 8'hA5; b_in = 8'h3C;
    tick;
    in_valid = 1'b0;
    tick; tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("abort_idle", in_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("abort_no_valid", out_valid, 1'b0);
    end
    run_op("after_abort", 8'h12, 8'h34, 0, 8'h46, 1'b0, 1'b0);

    // Back-to-back with operands churning every cycle.
    b2b = 1'b1; last_acc = -1;
    target = n_acc + 1000;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (n_acc < target && n < 1000 * (W + 2) + 50) begin
      a_in = W'($urandom); b_in = W'($urandom);
      tick; n++;
    end
    chk("b2b_count", n_acc, target);
    in_valid = 1'b0;
    b2b = 1'b0;
    for (int i = 0; i < W + 3; i++) tick;

    // Random handshakes and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_in = W'($urandom); b_in = W'($urandom);
      resetn = ($urandom_range(0, 199) != 0);
      tick;
    end
    resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < W + 3; i++) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
